tx_redundant_framer: RTL and testbench

Byte-level Ethernet frame generator for the transmit side of the redundant link. Each burst emits REDUNDANCY identical copies of a test frame: preamble/SFD, fixed MAC header, copy tag, 16-bit sequence id at byte index 25, deterministic payload and CRC-32 FCS. Frames are separated by an inter-frame gap. The output is a registered data/enable byte stream, paced by the speed-dependent `adv_data` strobe and feeding the RGMII transmit serializer. The far-end majority receiver votes across the copies, and the logger counts sequence ids.

---
 rtl/tx_redundant_framer_pkg.sv | 11 +
 rtl/eth_crc32_byte.sv | 14 +
 rtl/tx_redundant_framer.sv | 104 ++++++++++
 tb/tb_tx_redundant_framer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_redundant_framer_pkg.sv
// tx_redundant_framer_pkg: shared states and byte/CRC constants for the redundant-link framer
package tx_redundant_framer_pkg;
    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, FCS, GAP} state_t;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam logic [7:0] TAG0 = 8'hA5;
    localparam logic [7:0] TAG1 = 8'h5A;
    localparam int HDR_END = 26;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
endpackage

// File: rtl/eth_crc32_byte.sv
// eth_crc32_byte: one-byte step of the reflected IEEE CRC-32
module eth_crc32_byte
    import tx_redundant_framer_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);
    always_comb begin
        crc_next = crc_in ^ {24'd0, data};
        for (int b = 0; b < 8; b++)
            crc_next = crc_next[0] ? (crc_next >> 1) ^ CRC_POLY : crc_next >> 1;
    end
endmodule

// File: rtl/tx_redundant_framer.sv
// tx_redundant_framer: emits REDUNDANCY tagged copies of a sequenced test frame per burst
module tx_redundant_framer
    import tx_redundant_framer_pkg::*;
#(
    parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC     = 48'h00_0A_35_00_01_02,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          PAYLOAD_LEN = 46,
    parameter int          REDUNDANCY  = 3,
    parameter int          IFG         = 12,
    parameter logic [15:0] SEQ_INIT    = 16'h0000
) (
    input  logic        clk125MHz,
    input  logic        resetn,
    input  logic        enable,
    input  logic        adv_data,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic [15:0] seq_id,
    output logic        busy,
    output logic        burst_done
);
    localparam logic [10:0] PAY_END = 11'(HDR_END + PAYLOAD_LEN);
    localparam logic [10:0] FCS_END = 11'(HDR_END + PAYLOAD_LEN + 4);
    localparam logic [10:0] GAP_END = 11'(IFG - 1);
    localparam logic [3:0] LAST_COPY = 4'(REDUNDANCY - 1);

    state_t state, state_n;
    logic [10:0] idx, idx_n;
    logic [3:0] copy, copy_n;
    logic [31:0] crc, crc_upd, crc_next;
    logic [151:0] hdr;
    logic [4:0] hoff;
    logic [7:0] hbase, byte_n;
    logic [1:0] fk;
    logic done_n;

    eth_crc32_byte u_crc (.crc_in(crc), .data(tx_data), .crc_next(crc_next));

    always_comb begin
        state_n = state;
        idx_n = idx + 11'd1;
        copy_n = copy;
        done_n = 1'b0;
        case (state)
            IDLE: begin
                idx_n = '0;
                copy_n = '0;
                state_n = (enable && !burst_done) ? PREAMBLE : IDLE;
            end
            PREAMBLE: state_n = (idx == 11'd7) ? HEADER : PREAMBLE;
            HEADER: state_n = (idx == 11'(HDR_END)) ? PAYLOAD : HEADER;
            PAYLOAD: state_n = (idx == PAY_END) ? FCS : PAYLOAD;
            FCS: if (idx == FCS_END) begin
                state_n = GAP;
                idx_n = '0;
            end
            GAP: if (idx == GAP_END) begin
                idx_n = '0;
                done_n = copy == LAST_COPY;
                state_n = done_n ? IDLE : PREAMBLE;
                copy_n = done_n ? copy : copy + 4'd1;
            end
            default: state_n = IDLE;
        endcase
        // CRC register absorbs the byte currently on tx_data as the slot advances
        crc_upd = (state == HEADER || state == PAYLOAD) ? crc_next
                : (state == PREAMBLE && idx == 11'd7) ? CRC_INIT : crc;
        hdr = {DST_MAC, SRC_MAC, ETHERTYPE, TAG0, TAG1, 4'd0, copy_n, seq_id};
        hoff = 5'(idx_n - 11'd8);
        hbase = 8'd151 - {hoff, 3'b000};
        fk = 2'(idx_n - PAY_END - 11'd1);
        byte_n = state_n == PREAMBLE ? (idx_n == 11'd7 ? SFD_BYTE : PREAMBLE_BYTE)
               : state_n == HEADER ? hdr[hbase -: 8]
               : state_n == PAYLOAD ? seq_id[7:0] + idx_n[7:0] - 8'(HDR_END + 1)
               : state_n == FCS ? ~crc_upd[{fk, 3'b000} +: 8] : 8'h00;
    end

    always_ff @(posedge clk125MHz) begin
        if (!resetn) begin
            state <= IDLE;
            idx <= '0;
            copy <= '0;
            crc <= CRC_INIT;
            tx_data <= 8'h00;
            tx_en <= 1'b0;
            seq_id <= SEQ_INIT;
            busy <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= adv_data && done_n;
            if (adv_data) begin
                state <= state_n;
                idx <= idx_n;
                copy <= copy_n;
                crc <= crc_upd;
                tx_data <= byte_n;
                tx_en <= state_n != IDLE && state_n != GAP;
                busy <= state_n != IDLE;
                if (done_n) seq_id <= seq_id + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_tx_redundant_framer.sv
// tb_tx_redundant_framer: directed checks of burst framing, FCS, pacing, reset and sequence wrap
module tb_tx_redundant_framer;
    logic clk125MHz = 1'b0;
    logic resetn, enable, adv_data, resetn2, enable2, adv_data2;
    logic [7:0] tx_data, tx_data2;
    logic tx_en, tx_en2, busy, busy2, burst_done, burst_done2;
    logic [15:0] seq_id, seq_id2;
    int total = 0;
    int bad = 0;
    int n, m;
    bit sel = 1'b0;
    logic [7:0] td[$];
    bit te[$], bd[$], bz[$];
    logic [15:0] sq[$];
    logic [7:0] fr[0:7][0:79];
    int flen[0:7];
    int fst[0:7];
    int nfr;
    logic [7:0] ex[0:79];
    logic [7:0] sc[0:79];
    logic [7:0] ref0[0:79];
    logic [31:0] c;

    always #4 clk125MHz = ~clk125MHz;

    tx_redundant_framer dut (
        .clk125MHz(clk125MHz), .resetn(resetn), .enable(enable), .adv_data(adv_data),
        .tx_data(tx_data), .tx_en(tx_en), .seq_id(seq_id), .busy(busy), .burst_done(burst_done)
    );

    tx_redundant_framer #(.SEQ_INIT(16'hFFFF)) dut2 (
        .clk125MHz(clk125MHz), .resetn(resetn2), .enable(enable2), .adv_data(adv_data2),
        .tx_data(tx_data2), .tx_en(tx_en2), .seq_id(seq_id2), .busy(busy2), .burst_done(burst_done2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk125MHz);
        #1;
        td.push_back(sel ? tx_data2 : tx_data);
        te.push_back(sel ? tx_en2 : tx_en);
        bd.push_back(sel ? burst_done2 : burst_done);
        bz.push_back(sel ? busy2 : busy);
        sq.push_back(sel ? seq_id2 : seq_id);
    endtask

    task automatic clear();
        td.delete();
        te.delete();
        bd.delete();
        bz.delete();
        sq.delete();
    endtask

    function automatic logic [31:0] crc_ref(input int lo, input int hi);
        logic [31:0] r;
        logic fb;
        r = 32'hFFFF_FFFF;
        for (int i = lo; i <= hi; i++)
            for (int b = 0; b < 8; b++) begin
                fb = r[0] ^ sc[i][b];
                r = r >> 1;
                if (fb) r = r ^ 32'hEDB8_8320;
            end
        return ~r;
    endfunction

    task automatic build_exp(input logic [15:0] s, input logic [3:0] cp);
        logic [31:0] f;
        for (int i = 0; i < 7; i++) ex[i] = 8'h55;
        ex[7] = 8'hD5;
        for (int i = 8; i < 14; i++) ex[i] = 8'hFF;
        ex[14] = 8'h00; ex[15] = 8'h0A; ex[16] = 8'h35;
        ex[17] = 8'h00; ex[18] = 8'h01; ex[19] = 8'h02;
        ex[20] = 8'h88; ex[21] = 8'hB5; ex[22] = 8'hA5; ex[23] = 8'h5A;
        ex[24] = {4'd0, cp};
        ex[25] = s[15:8];
        ex[26] = s[7:0];
        for (int k = 0; k < 46; k++) ex[27 + k] = s[7:0] + 8'(k);
        for (int i = 0; i < 80; i++) sc[i] = ex[i];
        f = crc_ref(8, 72);
        ex[73] = f[7:0]; ex[74] = f[15:8]; ex[75] = f[23:16]; ex[76] = f[31:24];
    endtask

    task automatic extract();
        nfr = 0;
        for (int i = 0; i < td.size(); i++)
            if (te[i]) begin
                if (i == 0 || !te[i - 1]) begin
                    if (nfr < 8) nfr++;
                    fst[nfr - 1] = i;
                    flen[nfr - 1] = 0;
                end
                if (flen[nfr - 1] < 80) fr[nfr - 1][flen[nfr - 1]] = td[i];
                flen[nfr - 1]++;
            end
    endtask

    task automatic check_frame(input int f, input logic [15:0] s, input logic [3:0] cp);
        int mm;
        logic [31:0] r;
        mm = 0;
        build_exp(s, cp);
        chk($sformatf("f%0d_len", f), flen[f], 77);
        chk($sformatf("f%0d_copy_byte", f), fr[f][24], {28'd0, cp});
        chk($sformatf("f%0d_seq_bytes", f), {fr[f][25], fr[f][26]}, s);
        for (int i = 0; i < 77; i++) if (fr[f][i] !== ex[i]) mm++;
        chk($sformatf("f%0d_bytes_bad", f), mm, 0);
        for (int i = 0; i < 80; i++) sc[i] = fr[f][i];
        r = crc_ref(8, 72);
        chk($sformatf("f%0d_fcs", f), {fr[f][76], fr[f][75], fr[f][74], fr[f][73]}, r);
    endtask

    initial begin
        resetn = 0; enable = 0; adv_data = 0;
        resetn2 = 0; enable2 = 0; adv_data2 = 0;
        for (int i = 0; i < 9; i++) sc[i] = 8'h31 + 8'(i);
        chk("crc_ref_123456789", crc_ref(0, 8), 32'hCBF4_3926);
        repeat (3) @(posedge clk125MHz);
        #1;
        chk("rst_tx_en", tx_en, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_seq_id", seq_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_burst_done", burst_done, 0);
        chk("rst_seq_id2", seq_id2, 32'hFFFF);
        resetn = 1; resetn2 = 1; enable = 1; adv_data = 1;

        // two full-rate bursts; enable drops during copy 1 of the second
        clear();
        for (int i = 0; i < 545; i++) begin
            if (i == 369) enable = 0;
            step();
        end
        chk("first_byte", {te[0], td[0]}, 32'h155);
        chk("first_busy", bz[0], 1);
        extract();
        chk("frame_count", nfr, 6);
        for (int f = 0; f < 6; f++) check_frame(f, f < 3 ? 16'h0000 : 16'h0001, 4'(f % 3));
        for (int f = 0; f < 5; f++)
            chk($sformatf("gap_after_f%0d", f), fst[f + 1] - fst[f] - flen[f], f == 2 ? 14 : 12);
        n = 0;
        foreach (bd[i]) if (bd[i]) n++;
        chk("done_pulses", n, 2);
        chk("done_slot1", bd[267], 1);
        chk("seq_after_burst1", sq[267], 1);
        chk("busy_before_done1", bz[266], 1);
        chk("busy_at_done1", bz[267], 0);
        chk("no_start_with_done", te[268], 0);
        chk("restart_slot", {te[269], td[269]}, 32'h155);
        chk("done_slot2", bd[536], 1);
        chk("busy_before_done2", bz[535], 1);
        chk("busy_at_done2", bz[536], 0);
        n = 0;
        for (int i = 536; i < 545; i++) if (te[i]) n++;
        chk("no_preamble_after_drop", n, 0);
        for (int i = 0; i < 80; i++) ref0[i] = fr[0][i];
        for (int i = 0; i < 80; i++) sc[i] = fr[0][i];
        sc[40] = sc[40] ^ 8'h01;
        c = crc_ref(8, 72);
        chk("corrupt_detect", c == {fr[0][76], fr[0][75], fr[0][74], fr[0][73]}, 0);

        // reset in the middle of payload byte 40
        enable = 1;
        clear();
        repeat (68) step();
        chk("pre_reset_payload40", td[67], 8'h2A);
        chk("pre_reset_seq", sq[67], 2);
        resetn = 0;
        step();
        chk("mid_rst_tx_en", tx_en, 0);
        chk("mid_rst_seq", seq_id, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        resetn = 1;
        step();
        chk("post_rst_first", {tx_en, tx_data}, 32'h155);

        // 100 Mb pacing: one strobe every 10 cycles
        resetn = 0;
        enable = 0;
        repeat (2) step();
        resetn = 1;
        enable = 1;
        clear();
        for (int i = 0; i < 780; i++) begin
            adv_data = (i % 10 == 0);
            step();
        end
        m = 0;
        for (int k = 0; k < 77; k++)
            for (int j = 0; j < 10; j++)
                if (td[10 * k + j] !== ref0[k] || !te[10 * k + j]) m++;
        chk("paced_bytes_bad", m, 0);
        chk("paced_gap_start", te[770], 0);
        adv_data = 0;
        enable = 0;

        // sequence wrap from 0xFFFF
        sel = 1;
        enable2 = 1;
        adv_data2 = 1;
        clear();
        repeat (300) step();
        enable2 = 0;
        extract();
        chk("wrap_frame_count", nfr, 4);
        check_frame(0, 16'hFFFF, 4'd0);
        chk("wrap_payload0", fr[0][27], 8'hFF);
        chk("wrap_payload1", fr[0][28], 8'h00);
        chk("wrap_seq_after", sq[267], 0);
        chk("wrap_next_seq", {fr[3][25], fr[3][26]}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
